// File: rtl/fir_acq_ctrl.sv
// Acquisition sequencer for the unrolled sine-mix/FIR datapath: gates ADC words, primes the
// tap window, flags valid output words and owns the active/shadow coefficient banks.
module fir_acq_ctrl #(
   parameter int CWIDTH     = 11,
   parameter int NTAP       = 37,
   parameter int UNR        = 4,
   parameter int FILL_WORDS = (NTAP - 1 + UNR + UNR - 1) / UNR,
   parameter int PIPE_LAT   = 3,
   parameter int NW         = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        cfg_we,
   input  logic [5:0]                  cfg_addr,
   input  logic [CWIDTH-1:0]           cfg_data,
   input  logic                        cfg_swap,
   output logic                        cfg_err,
   output logic                        swap_pend,
   output logic [NTAP-1:0][CWIDTH-1:0] coeff,
   input  logic                        start,
   input  logic [NW-1:0]               nwords,
   input  logic                        abort,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        EN,
   output logic                        out_valid,
   output logic                        busy,
   output logic                        done,
   output logic                        aborted
);

   localparam int FW = $clog2(FILL_WORDS) + 1;
   localparam logic [FW-1:0] FILL_LAST = FW'(FILL_WORDS - 2);
   localparam logic [5:0] NTAP_A = 6'(NTAP);

   typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

   state_t                      state;
   logic [NTAP-1:0][CWIDTH-1:0] shadow, shadow_w;
   logic [FW-1:0]               fill_cnt;
   logic [NW-1:0]               nw_lat, run_cnt;
   logic [PIPE_LAT-1:0]         vpipe, vpipe_nx;
   logic                        accept, push, bad_addr, abort_go, swap_apply;

   // abort wins over a same-cycle accept
   assign accept     = in_valid & in_ready & ~abort;
   assign EN         = accept;
   assign push       = accept && (state == RUN);
   assign vpipe_nx   = (vpipe << 1) | PIPE_LAT'(push);
   assign out_valid  = vpipe[PIPE_LAT-1];
   assign bad_addr   = cfg_we && (cfg_addr >= NTAP_A);
   assign abort_go   = abort && (state != IDLE);
   assign swap_apply = swap_pend && ((state == IDLE) || (state == DONE) || abort_go);

   // Shadow contents including this cycle's write, so a same-cycle swap promotes it.
   always_comb begin
      shadow_w = shadow;
      if (cfg_we && !bad_addr) shadow_w[cfg_addr] = cfg_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         shadow    <= '0;
         coeff     <= '0;
         swap_pend <= 1'b0;
         cfg_err   <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         fill_cnt  <= '0;
         run_cnt   <= '0;
         nw_lat    <= '0;
         vpipe     <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         cfg_err <= bad_addr;
         shadow  <= shadow_w;
         vpipe   <= vpipe_nx;

         if (swap_apply) begin
            coeff     <= shadow_w;
            shadow    <= coeff;
            swap_pend <= 1'b0;
         end else if (cfg_swap) begin
            swap_pend <= 1'b1;
         end

         if (abort_go) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            vpipe    <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && (nwords != '0)) begin
                     nw_lat   <= nwords;
                     run_cnt  <= '0;
                     fill_cnt <= '0;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                     state    <= (FILL_WORDS == 1) ? RUN : FILL;
                  end
               end
               FILL: begin
                  if (accept) begin
                     fill_cnt <= fill_cnt + 1'b1;
                     if (fill_cnt == FILL_LAST) state <= RUN;
                  end
               end
               RUN: begin
                  if (accept) begin
                     run_cnt <= run_cnt + 1'b1;
                     if (run_cnt == nw_lat - 1'b1) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (vpipe_nx == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
